// File: rtl/hazard_ctrl.sv
// Pipeline hazard/redirect controller: load-use stall, branch/jump redirect with squash, mul/div EX hold.
// Latency: stall/id_ex_bubble/ex_hold combinational; PCsel/Addr_result one cycle after take; flush two cycles.
// Backpressure: stall holds PC and IF/ID, ex_hold holds EX for MULDIV_CYCLES; flush outranks load-use stall.
module hazard_ctrl #(
    parameter int MULDIV_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        ex_valid,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_branch,
    input  logic        ex_jump,
    input  logic        ex_branch_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_muldiv,
    output logic        stall,
    output logic        id_ex_bubble,
    output logic        flush,
    output logic        PCsel,
    output logic [31:0] Addr_result,
    output logic        ex_hold,
    output logic        muldiv_busy,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(MULDIV_CYCLES - 2);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        redir_q;
    logic        flush_tail;
    logic        take;
    logic        lu;
    logic        rs1_hit;
    logic        rs2_hit;
    logic        muldiv_issue;
    logic        mul_hold;
    logic        flush_int;

    assign take = ex_valid & (ex_jump | (ex_branch & ex_branch_taken));

    assign rs1_hit = id_uses_rs1 & (id_rs1 == ex_rd);
    assign rs2_hit = id_uses_rs2 & (id_rs2 == ex_rd);
    assign lu      = ex_valid & ex_mem_read & (ex_rd != 5'd0) & (rs1_hit | rs2_hit);

    // A redirecting instruction cannot also be a mul/div; the redirect wins.
    assign muldiv_issue = ex_valid & ex_muldiv & ~take;

    assign flush_int = redir_q | flush_tail;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mul_hold = 1'b0;
        case (state_q)
            IDLE: begin
                if (muldiv_issue) begin
                    mul_hold = 1'b1;
                    state_d  = BUSY;
                    cnt_d    = CNT_LOAD;
                end
            end
            BUSY: begin
                mul_hold = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Gated by reset so a mid-operation reset drops every hold at once.
    always_comb begin
        flush        = flush_int & ~reset;
        id_ex_bubble = lu & ~flush_int & ~reset;
        ex_hold      = mul_hold & ~reset;
        stall        = (mul_hold | (lu & ~flush_int)) & ~reset;
        muldiv_busy  = (state_q == BUSY) & ~reset;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            redir_q     <= 1'b0;
            flush_tail  <= 1'b0;
            PCsel       <= 1'b0;
            Addr_result <= 32'h0;
        end else begin
            redir_q    <= take;
            flush_tail <= redir_q;
            PCsel      <= take;
            if (take) begin
                Addr_result <= ex_target;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt <= 16'h0;
            flush_cnt <= 16'h0;
        end else begin
            if (stall && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (flush && (flush_cnt != 16'hFFFF)) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: reset, load-use, redirects, mul/div hold, flush priority, saturation.
module tb_hazard_ctrl;

    logic        clock;
    logic        reset;
    logic [4:0]  id_rs1, id_rs2;
    logic        id_uses_rs1, id_uses_rs2;
    logic        ex_valid;
    logic [4:0]  ex_rd;
    logic        ex_mem_read, ex_branch, ex_jump, ex_branch_taken;
    logic [31:0] ex_target;
    logic        ex_muldiv;
    logic        stall, id_ex_bubble, flush, PCsel, ex_hold, muldiv_busy;
    logic [31:0] Addr_result;
    logic [15:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    hazard_ctrl #(.MULDIV_CYCLES(4)) dut (
        .clock           (clock),
        .reset           (reset),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_valid        (ex_valid),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_branch       (ex_branch),
        .ex_jump         (ex_jump),
        .ex_branch_taken (ex_branch_taken),
        .ex_target       (ex_target),
        .ex_muldiv       (ex_muldiv),
        .stall           (stall),
        .id_ex_bubble    (id_ex_bubble),
        .flush           (flush),
        .PCsel           (PCsel),
        .Addr_result     (Addr_result),
        .ex_hold         (ex_hold),
        .muldiv_busy     (muldiv_busy),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then changed well away from it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_valid = 1'b0; ex_rd = 5'd0; ex_mem_read = 1'b0; ex_branch = 1'b0;
        ex_jump = 1'b0; ex_branch_taken = 1'b0; ex_target = 32'h0; ex_muldiv = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic set_lu(input logic [4:0] rd);
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = rd;
        id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        do_reset();
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_pcsel", 32'(PCsel), 32'd0);
        check("rst_addr", Addr_result, 32'h0);
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_cnts", {stall_cnt, flush_cnt}, 32'h0);

        // Load-use on rs2, then the same with ex_rd=0 (x0 never hazards)
        set_lu(5'd5);
        #1;
        check("lu_stall", 32'(stall), 32'd1);
        check("lu_bubble", 32'(id_ex_bubble), 32'd1);
        check("lu_exhold", 32'(ex_hold), 32'd0);
        set_lu(5'd0);
        id_rs2 = 5'd0;
        #1;
        check("lu_x0_stall", 32'(stall), 32'd0);
        check("lu_x0_bubble", 32'(id_ex_bubble), 32'd0);
        idle_inputs();
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b0;
        #1;
        check("lu_unused_rs1", 32'(stall), 32'd0);
        id_uses_rs1 = 1'b1;
        #1;
        check("lu_rs1_stall", 32'(stall), 32'd1);

        // Taken branch to 0x40
        do_reset();
        ex_valid = 1'b1; ex_branch = 1'b1; ex_branch_taken = 1'b1; ex_target = 32'h40;
        tick();
        idle_inputs();
        #1;
        check("br_pcsel", 32'(PCsel), 32'd1);
        check("br_addr", Addr_result, 32'h40);
        check("br_flush1", 32'(flush), 32'd1);
        tick();
        check("br_pcsel_off", 32'(PCsel), 32'd0);
        check("br_flush2", 32'(flush), 32'd1);
        tick();
        check("br_flush3", 32'(flush), 32'd0);
        check("br_flush_cnt", 32'(flush_cnt), 32'd2);
        check("br_addr_hold", Addr_result, 32'h40);

        // Not-taken branch
        ex_valid = 1'b1; ex_branch = 1'b1; ex_branch_taken = 1'b0; ex_target = 32'h80;
        tick();
        idle_inputs();
        #1;
        check("nt_pcsel", 32'(PCsel), 32'd0);
        check("nt_flush", 32'(flush), 32'd0);
        check("nt_addr", Addr_result, 32'h40);

        // Jump to 0x100
        ex_valid = 1'b1; ex_jump = 1'b1; ex_target = 32'h100;
        tick();
        idle_inputs();
        #1;
        check("jmp_pcsel", 32'(PCsel), 32'd1);
        check("jmp_addr", Addr_result, 32'h100);
        tick();
        check("jmp_pcsel_off", 32'(PCsel), 32'd0);

        // Back-to-back takes: two pulses, three flush cycles
        do_reset();
        ex_valid = 1'b1; ex_jump = 1'b1; ex_target = 32'h200;
        tick();
        ex_target = 32'h300;
        #1;
        check("b2b_addr1", Addr_result, 32'h200);
        check("b2b_pcsel1", 32'(PCsel), 32'd1);
        tick();
        idle_inputs();
        #1;
        check("b2b_addr2", Addr_result, 32'h300);
        check("b2b_pcsel2", 32'(PCsel), 32'd1);
        tick();
        check("b2b_flush_tail", 32'(flush), 32'd1);
        tick();
        check("b2b_flush_cnt", 32'(flush_cnt), 32'd3);

        // Mul/div: 4 stall cycles, busy for the last 3
        do_reset();
        ex_valid = 1'b1; ex_muldiv = 1'b1;
        #1;
        check("md_c0_stall", 32'(stall), 32'd1);
        check("md_c0_hold", 32'(ex_hold), 32'd1);
        check("md_c0_busy", 32'(muldiv_busy), 32'd0);
        tick();
        ex_muldiv = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            #1;
            check($sformatf("md_c%0d_stall", c), 32'(stall), 32'd1);
            check($sformatf("md_c%0d_busy", c), 32'(muldiv_busy), 32'd1);
            tick();
        end
        check("md_done_stall", 32'(stall), 32'd0);
        check("md_done_hold", 32'(ex_hold), 32'd0);
        check("md_done_busy", 32'(muldiv_busy), 32'd0);
        check("md_stall_cnt", 32'(stall_cnt), 32'd4);

        // ex_muldiv together with a jump: redirect only
        do_reset();
        ex_valid = 1'b1; ex_jump = 1'b1; ex_muldiv = 1'b1; ex_target = 32'h500;
        #1;
        check("mdj_stall", 32'(stall), 32'd0);
        tick();
        idle_inputs();
        #1;
        check("mdj_busy", 32'(muldiv_busy), 32'd0);
        check("mdj_pcsel", 32'(PCsel), 32'd1);

        // Reset asserted mid-BUSY (cnt=2)
        do_reset();
        ex_valid = 1'b1; ex_muldiv = 1'b1;
        tick();
        ex_muldiv = 1'b0;
        #1;
        check("rbusy_pre", 32'(muldiv_busy), 32'd1);
        reset = 1'b1;
        #1;
        check("rbusy_stall", 32'(stall), 32'd0);
        check("rbusy_busy", 32'(muldiv_busy), 32'd0);
        check("rbusy_hold", 32'(ex_hold), 32'd0);
        check("rbusy_cnt", 32'(stall_cnt), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("rbusy_after", 32'(stall), 32'd0);
        check("rbusy_cnt2", 32'(stall_cnt), 32'd0);

        // Flush overrides load-use for both squash cycles
        do_reset();
        ex_valid = 1'b1; ex_branch = 1'b1; ex_branch_taken = 1'b1; ex_target = 32'h60;
        tick();
        idle_inputs();
        set_lu(5'd5);
        #1;
        check("fl_lu_stall1", 32'(stall), 32'd0);
        check("fl_lu_bubble1", 32'(id_ex_bubble), 32'd0);
        tick();
        check("fl_lu_stall2", 32'(stall), 32'd0);
        tick();
        check("fl_lu_stall3", 32'(stall), 32'd1);
        check("fl_lu_bubble3", 32'(id_ex_bubble), 32'd1);

        // Stall counter saturation under a held load-use
        do_reset();
        set_lu(5'd5);
        repeat (65540) @(posedge clock);
        #1;
        check("sat_stall_cnt", 32'(stall_cnt), 32'h0000FFFF);
        check("sat_flush_cnt", 32'(flush_cnt), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
